// File: rtl/branch_sched_pkg.sv
// Shared constants for the branch resolution controller: branch funct3 codes,
// 2-bit BHT counter encodings and the flush FSM state encodings.
package branch_sched_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/branch_sched_bht_2bit.sv
// bht_2bit: table of 2-bit saturating counters with one combinational read
// port and one synchronous update port; reset loads every entry with WNT.
module bht_2bit
    import branch_sched_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_state,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    bht_state_e r_table [ENTRIES];

    function automatic bht_state_e sat_update(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        case (cur)
            BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
            default: nxt = taken ? BHT_ST  : BHT_WT;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= BHT_WNT;
            end
        end else if (i_upd_en) begin
            r_table[i_upd_idx] <= sat_update(r_table[i_upd_idx], i_upd_taken);
        end
    end

    // No write-to-read bypass: a same-cycle update is seen on the next cycle.
    assign o_rd_state = r_table[i_rd_idx];

endmodule

// File: rtl/branch_sched.sv
// branch_sched: EX-stage branch resolution, BHT training and mispredict redirect/flush.
// Optional macro BRANCH_SCHED_STATS_EN adds stat_branches / stat_mispredicts counters.
module branch_sched
    import branch_sched_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic        ex_pred_taken,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic [2:0]  cmp_funct3,
    input  logic        cmp_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
`ifdef BRANCH_SCHED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int         IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    fsm_state_e       r_state;
    fsm_state_e       w_state_next;
    logic [2:0]       r_flush_cnt;
    logic [2:0]       w_flush_cnt_next;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic             w_resolve;
    logic             w_mispredict;
    logic [1:0]       w_pred_state;
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_unused_bits;

    assign cmp_a      = ex_rs1;
    assign cmp_b      = ex_rs2;
    assign cmp_funct3 = ex_funct3;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign w_unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], w_pred_state[0]};

    // EX inputs are only honoured in RUN; while flushing they belong to killed instructions.
    assign w_resolve    = (r_state == ST_RUN) && ex_valid && ex_is_branch;
    assign w_mispredict = w_resolve && (cmp_taken != ex_pred_taken);

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_if_idx),
        .o_rd_state  (w_pred_state),
        .i_upd_en    (w_resolve),
        .i_upd_idx   (w_ex_idx),
        .i_upd_taken (cmp_taken)
    );

    assign pred_taken = w_pred_state[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // Counter is loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mispredict) begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 3'd0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next     = ST_RUN;
                w_flush_cnt_next = 3'd0;
            end
        endcase
    end

    always_comb begin
        flush = 1'b0;
        if (r_state == ST_FLUSH) begin
            flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= cmp_taken ? ex_target : (ex_pc + 32'd4);
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (w_resolve) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_sched.sv
// Directed self-checking bench for branch_sched; the bench plays the EX comparator.
// Stats scenario is built only when BRANCH_SCHED_STATS_EN is defined.
module tb_branch_sched;
    import branch_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic [31:0] ex_target = 32'd0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_rs1 = 32'd0;
    logic [31:0] ex_rs2 = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [2:0]  cmp_funct3;
    logic        cmp_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Branch comparator of the EX stage, driven from the DUT's cmp_* outputs.
    always_comb begin
        case (cmp_funct3)
            F3_BEQ:  cmp_taken = (cmp_a == cmp_b);
            F3_BNE:  cmp_taken = (cmp_a != cmp_b);
            F3_BLT:  cmp_taken = ($signed(cmp_a) <  $signed(cmp_b));
            F3_BGE:  cmp_taken = ($signed(cmp_a) >= $signed(cmp_b));
            F3_BLTU: cmp_taken = (cmp_a <  cmp_b);
            F3_BGEU: cmp_taken = (cmp_a >= cmp_b);
            default: cmp_taken = 1'b0;
        endcase
    end

    branch_sched #(
        .BHT_ENTRIES  (16),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_funct3      (ex_funct3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pred_taken  (ex_pred_taken),
        .cmp_a          (cmp_a),
        .cmp_b          (cmp_b),
        .cmp_funct3     (cmp_funct3),
        .cmp_taken      (cmp_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
`ifdef BRANCH_SCHED_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        rst          = 1'b1;
        tick(2);
        rst          = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_funct3     = f3;
        ex_rs1        = a;
        ex_rs2        = b;
        ex_pred_taken = pred;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic pred);
        drive(pc, tgt, f3, a, b, pred);
        tick(1);
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        if_pc = 32'h0000_0040;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL rst_pred: got %b want 0", pred_taken); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL rst_redir_valid: got %b want 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'd0) begin n_errors++; $display("FAIL rst_redir_pc: got %h want 0", redirect_pc); end
    endtask

    task automatic test_mispredict_taken();
        apply_reset();
        drive(32'h100, 32'h80, F3_BEQ, 32'd5, 32'd5, 1'b0);
        #1;
        n_checks++; if (cmp_a !== 32'd5) begin n_errors++; $display("FAIL cmp_a: got %h want 5", cmp_a); end
        n_checks++; if (cmp_b !== 32'd5) begin n_errors++; $display("FAIL cmp_b: got %h want 5", cmp_b); end
        n_checks++; if (cmp_funct3 !== 3'b000) begin n_errors++; $display("FAIL cmp_funct3: got %b want 000", cmp_funct3); end
        tick(1);
        ex_valid = 1'b0; ex_is_branch = 1'b0;
        n_checks++; if (redirect_valid !== 1'b1) begin n_errors++; $display("FAIL mpt_redir_valid: got %b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h80) begin n_errors++; $display("FAIL mpt_redir_pc: got %h want 00000080", redirect_pc); end
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL mpt_flush1: got %b want 1", flush); end
        tick(1);
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL mpt_redir_once: got %b want 0", redirect_valid); end
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL mpt_flush2: got %b want 1", flush); end
        tick(1);
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL mpt_flush_end: got %b want 0", flush); end
        if_pc = 32'h100;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL mpt_bht_wt: got %b want 1", pred_taken); end
    endtask

    task automatic test_mispredict_not_taken();
        apply_reset();
        // 0xFFFFFFFF <u 1 is false, predicted taken
        resolve(32'h200, 32'h600, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 1'b1);
        n_checks++; if (redirect_valid !== 1'b1) begin n_errors++; $display("FAIL mpn_redir_valid: got %b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h204) begin n_errors++; $display("FAIL mpn_redir_pc: got %h want 00000204", redirect_pc); end
        tick(2);
        // Entry now SNT: one taken step must leave it at WNT (not-taken prediction)
        resolve(32'h200, 32'h600, F3_BEQ, 32'd9, 32'd9, 1'b0);
        n_checks++; if (redirect_pc !== 32'h600) begin n_errors++; $display("FAIL mpn_redir_tgt: got %h want 00000600", redirect_pc); end
        tick(2);
        if_pc = 32'h200;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL mpn_bht_snt: got %b want 0", pred_taken); end
        // pc+4 wraps modulo 2^32
        resolve(32'hFFFF_FFFC, 32'h10, F3_BNE, 32'd7, 32'd7, 1'b1);
        n_checks++; if (redirect_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_redir_valid: got %b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'd0) begin n_errors++; $display("FAIL wrap_redir_pc: got %h want 00000000", redirect_pc); end
        tick(2);
    endtask

    task automatic test_saturate();
        apply_reset();
        // -1 <s 1: taken. WNT -> WT (mispredict), then back-to-back WT -> ST -> ST.
        resolve(32'h300, 32'h700, F3_BLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        n_checks++; if (redirect_valid !== 1'b1) begin n_errors++; $display("FAIL sat_first_redir: got %b want 1", redirect_valid); end
        tick(2);
        resolve(32'h300, 32'h700, F3_BLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL sat_b2b1_redir: got %b want 0", redirect_valid); end
        resolve(32'h300, 32'h700, F3_BGEU, 32'd8, 32'd3, 1'b1);
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL sat_b2b2_flush: got %b want 0", flush); end
        resolve(32'h300, 32'h700, F3_BGE, 32'd3, 32'd3, 1'b1);
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL sat_st_redir: got %b want 0", redirect_valid); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL sat_st_flush: got %b want 0", flush); end
        // One not-taken from ST lands on WT, still predicting taken
        resolve(32'h300, 32'h700, F3_BLT, 32'd5, 32'd3, 1'b1);
        n_checks++; if (redirect_pc !== 32'h304) begin n_errors++; $display("FAIL sat_nt_redir_pc: got %h want 00000304", redirect_pc); end
        tick(2);
        if_pc = 32'h300;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL sat_st_to_wt: got %b want 1", pred_taken); end
    endtask

    task automatic test_flush_ignore();
        apply_reset();
        resolve(32'h100, 32'h80, F3_BEQ, 32'd1, 32'd1, 1'b0);
        // Mispredict pattern held through both flush cycles, including the exit cycle
        drive(32'h144, 32'h900, F3_BEQ, 32'd2, 32'd2, 1'b0);
        tick(1);
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL fign_redir1: got %b want 0", redirect_valid); end
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL fign_flush1: got %b want 1", flush); end
        tick(1);
        ex_valid = 1'b0; ex_is_branch = 1'b0;
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL fign_redir2: got %b want 0", redirect_valid); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL fign_flush2: got %b want 0", flush); end
        n_checks++; if (redirect_pc !== 32'h80) begin n_errors++; $display("FAIL fign_redir_pc: got %h want 00000080", redirect_pc); end
        if_pc = 32'h144;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL fign_bht: got %b want 0", pred_taken); end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        resolve(32'h100, 32'h80, F3_BEQ, 32'd1, 32'd1, 1'b0);
        tick(1);
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL rmf_flush_pre: got %b want 1", flush); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rmf_flush_post: got %b want 0", flush); end
        // Reset in the first flush cycle: flush would otherwise still be high next cycle
        resolve(32'h100, 32'h80, F3_BEQ, 32'd1, 32'd1, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL rmf1_flush: got %b want 0", flush); end
        n_checks++; if (redirect_pc !== 32'd0) begin n_errors++; $display("FAIL rmf1_redir_pc: got %h want 0", redirect_pc); end
        resolve(32'h100, 32'h88, F3_BEQ, 32'd1, 32'd1, 1'b0);
        n_checks++; if (redirect_valid !== 1'b1) begin n_errors++; $display("FAIL rmf_run_redir: got %b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h88) begin n_errors++; $display("FAIL rmf_run_redir_pc: got %h want 00000088", redirect_pc); end
        tick(2);
    endtask

`ifdef BRANCH_SCHED_STATS_EN
    task automatic test_stats();
        apply_reset();
        n_checks++; if (stat_branches !== 32'd0) begin n_errors++; $display("FAIL stat_br_rst: got %0d want 0", stat_branches); end
        n_checks++; if (stat_mispredicts !== 32'd0) begin n_errors++; $display("FAIL stat_mp_rst: got %0d want 0", stat_mispredicts); end
        resolve(32'h400, 32'h800, F3_BEQ, 32'd1, 32'd1, 1'b0);
        tick(2);
        resolve(32'h400, 32'h800, F3_BEQ, 32'd1, 32'd1, 1'b1);
        resolve(32'h400, 32'h800, F3_BEQ, 32'd1, 32'd1, 1'b1);
        resolve(32'h400, 32'h800, F3_BEQ, 32'd1, 32'd2, 1'b1);
        tick(2);
        resolve(32'h400, 32'h800, F3_BEQ, 32'd1, 32'd1, 1'b1);
        n_checks++; if (stat_branches !== 32'd5) begin n_errors++; $display("FAIL stat_br: got %0d want 5", stat_branches); end
        n_checks++; if (stat_mispredicts !== 32'd2) begin n_errors++; $display("FAIL stat_mp: got %0d want 2", stat_mispredicts); end
    endtask
`endif

    initial begin
        test_reset();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_saturate();
        test_flush_ignore();
        test_reset_mid_flush();
`ifdef BRANCH_SCHED_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
